sp_ram_ctrl: RTL

SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

---
 rtl/sp_ram_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sp_ram_ctrl.sv
// Burst controller for a synchronous single-port RAM with a shared tri-state data bus.
// Define SP_RAM_CTRL_RD_WAIT_EN to hold each read address for two cycles and sample one cycle later.
module sp_ram_ctrl #(
  parameter int ADDR  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             req_wr,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             ready,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             chip_sel,
  output logic             wr_rd,
  output logic             op_en,
  output logic [ADDR-1:0]  addr_out,
  inout  logic [WIDTH-1:0] data_in_out
);

`ifdef SP_RAM_CTRL_RD_WAIT_EN
  localparam bit RD_WAIT = 1'b1;
`else
  localparam bit RD_WAIT = 1'b0;
`endif

  localparam logic [LEN_W:0] ONE_BEAT = (LEN_W+1)'(1);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t           state_q, state_d;
  logic [ADDR-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W:0]   beats_q, beats_d;
  logic             phase_q, phase_d;
  logic             chip_sel_q, chip_sel_d;
  logic             wr_rd_q, wr_rd_d;
  logic             op_en_q, op_en_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic             drive_q, drive_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             beat_q, beat_d;
  logic [1:0]       pend_q;
  logic             sample;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             done_q, done_d;
  logic [ADDR-1:0]  next_addr;

  assign next_addr = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR'(1);
  // pend_q tracks issued read beats until their data is on the bus
  assign sample    = RD_WAIT ? pend_q[1] : pend_q[0];

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beats_d    = beats_q;
    phase_d    = phase_q;
    chip_sel_d = 1'b0;
    wr_rd_d    = wr_rd_q;
    op_en_d    = op_en_q;
    addr_d     = addr_q;
    drive_d    = 1'b0;
    wdata_d    = wdata_q;
    beat_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cur_addr_d = req_addr;
          beats_d    = {1'b0, req_len} + ONE_BEAT;
          phase_d    = 1'b0;
          state_d    = req_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          chip_sel_d = 1'b1;
          wr_rd_d    = 1'b1;
          op_en_d    = 1'b0;
          addr_d     = cur_addr_q;
          drive_d    = 1'b1;
          wdata_d    = wdata;
          cur_addr_d = next_addr;
          beats_d    = beats_q - ONE_BEAT;
          if (beats_q == ONE_BEAT) begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        chip_sel_d = 1'b1;
        wr_rd_d    = 1'b0;
        op_en_d    = 1'b1;
        addr_d     = cur_addr_q;
        if (RD_WAIT && !phase_q) begin
          phase_d = 1'b1;
          beat_d  = 1'b1;
        end else begin
          phase_d    = 1'b0;
          beat_d     = !RD_WAIT;
          cur_addr_d = next_addr;
          beats_d    = beats_q - ONE_BEAT;
          if (beats_q == ONE_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // leave only once the bus is idle and no read data is still in flight
        if (!chip_sel_q && !beat_q && (pend_q == 2'b00)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      beats_q    <= '0;
      phase_q    <= 1'b0;
      chip_sel_q <= 1'b0;
      wr_rd_q    <= 1'b0;
      op_en_q    <= 1'b0;
      addr_q     <= '0;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      beat_q     <= 1'b0;
      pend_q     <= 2'b00;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beats_q    <= beats_d;
      phase_q    <= phase_d;
      chip_sel_q <= chip_sel_d;
      wr_rd_q    <= wr_rd_d;
      op_en_q    <= op_en_d;
      addr_q     <= addr_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
      pend_q     <= {RD_WAIT & pend_q[0], beat_q};
      rd_valid_q <= sample;
      if (sample) begin
        rd_data_q <= data_in_out;
      end
      done_q     <= done_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign chip_sel    = chip_sel_q;
  assign wr_rd       = wr_rd_q;
  assign op_en       = op_en_q;
  assign addr_out    = addr_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign data_in_out = drive_q ? wdata_q : 'z;

endmodule
